// File: rtl/icb_wfifo_packer_pkg.sv
// icb_apb_pkg: word layout, slave select codes and FSM states
// shared by the ICB packer and the APB master that drains the WFIFO.
package icb_apb_pkg;

  localparam int WORD_W         = 32;
  localparam int WORD_DATA_BIT  = 0;
  localparam int WORD_WRITE_BIT = 1;
  localparam int SEL_LO         = 2;
  localparam int SEL_W          = 6;
  localparam int ADDR_LO        = 8;
  localparam int ADDR_W         = 24;

  localparam logic [SEL_W-1:0] SEL_S0 = 6'b000001;
  localparam logic [SEL_W-1:0] SEL_S1 = 6'b000010;
  localparam logic [SEL_W-1:0] SEL_S2 = 6'b000100;
  localparam logic [SEL_W-1:0] SEL_S3 = 6'b001000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_RD_WAIT,
    ST_RD_POP,
    ST_RSP
  } state_t;

  function automatic logic [WORD_W-1:0] pack_cmd(
    input logic              wr,
    input logic [SEL_W-1:0]  sel,
    input logic [ADDR_W-1:0] addr
  );
    logic [WORD_W-1:0] w;
    w                    = '0;
    w[WORD_DATA_BIT]     = 1'b0;
    w[WORD_WRITE_BIT]    = wr;
    w[SEL_LO +: SEL_W]   = sel;
    w[ADDR_LO +: ADDR_W] = addr;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] pack_data(
    input logic [WORD_W-2:0] d
  );
    logic [WORD_W-1:0] w;
    w                = {d, 1'b0};
    w[WORD_DATA_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/icb_wfifo_packer_if.sv
// icb_wfifo_packer_if: ICB cmd/rsp channels plus WFIFO/RFIFO ports.
// slave = packer view, master = ICB host / FIFO side view.
interface icb_wfifo_packer_if;
  import icb_apb_pkg::*;

  logic              icb_cmd_valid;
  logic              icb_cmd_ready;
  logic [WORD_W-1:0] icb_cmd_addr;
  logic              icb_cmd_read;
  logic [WORD_W-1:0] icb_cmd_wdata;
  logic              icb_rsp_valid;
  logic              icb_rsp_ready;
  logic [WORD_W-1:0] icb_rsp_rdata;
  logic              icb_rsp_err;
  logic              wfifo_full;
  logic              wfifo_wen;
  logic [WORD_W-1:0] wfifo_wdata;
  logic              rfifo_empty;
  logic              rfifo_ren;
  logic [WORD_W-1:0] rfifo_rdata;

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read,
    input  icb_cmd_wdata, icb_rsp_ready,
    input  wfifo_full, rfifo_empty, rfifo_rdata,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata,
    output icb_rsp_err, wfifo_wen, wfifo_wdata, rfifo_ren
  );

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read,
    output icb_cmd_wdata, icb_rsp_ready,
    output wfifo_full, rfifo_empty, rfifo_rdata,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata,
    input  icb_rsp_err, wfifo_wen, wfifo_wdata, rfifo_ren
  );

endinterface

// File: rtl/icb_wfifo_packer_addr_decode.sv
// icb_addr_decode: base-window hit check and one-hot slave select.
// Pure combinational; also hands back the 24-bit packed address.
module icb_addr_decode
  import icb_apb_pkg::*;
#(
  parameter int         SEL_LSB = 12,
  parameter logic [7:0] BASE_HI = 8'h10
) (
  input  logic [WORD_W-1:0] i_addr,
  output logic              o_hit,
  output logic [SEL_W-1:0]  o_sel,
  output logic [ADDR_W-1:0] o_addr
);

  logic [1:0] w_idx;

  assign w_idx  = i_addr[SEL_LSB+1:SEL_LSB];
  assign o_hit  = (i_addr[31:24] == BASE_HI);
  assign o_addr = i_addr[ADDR_W-1:0];

  // slave index -> one-hot select
  always_comb begin
    o_sel = SEL_S0;
    unique case (w_idx)
      2'd0: o_sel = SEL_S0;
      2'd1: o_sel = SEL_S1;
      2'd2: o_sel = SEL_S2;
      2'd3: o_sel = SEL_S3;
    endcase
  end

endmodule

// File: rtl/icb_wfifo_packer.sv
// icb_wfifo_packer: ICB front stage, packs cmd/data words into WFIFO.
// Optional read watchdog enabled by `define ICB_PACKER_TIMEOUT_EN.
module icb_wfifo_packer
  import icb_apb_pkg::*;
#(
  parameter int         SEL_LSB     = 12,
  parameter logic [7:0] BASE_HI     = 8'h10,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              control_en,
  icb_wfifo_packer_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  logic              r_write;
  logic              r_err;
  logic [WORD_W-1:0] r_cmd_word;
  logic [WORD_W-1:0] r_data_word;
  logic [WORD_W-1:0] r_rdata;
  logic              w_hit;
  logic [SEL_W-1:0]  w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic              w_accept;
  logic              w_to;
  logic              w_unused_wd;

  icb_addr_decode #(
    .SEL_LSB (SEL_LSB),
    .BASE_HI (BASE_HI)
  ) u_dec (
    .i_addr (bus.icb_cmd_addr),
    .o_hit  (w_hit),
    .o_sel  (w_sel),
    .o_addr (w_addr)
  );

  assign w_accept = (r_state == ST_IDLE) & control_en
                  & ~rst & bus.icb_cmd_valid;

  // bit31 of write data has no slot in the data word
  assign w_unused_wd = bus.icb_cmd_wdata[31];

`ifdef ICB_PACKER_TIMEOUT_EN
  logic [15:0] r_tmo;

  // count cycles spent waiting for read data; cleared elsewhere
  always_ff @(posedge clk) begin
    if (rst)
      r_tmo <= '0;
    else if (r_state == ST_RD_WAIT)
      r_tmo <= r_tmo + 16'd1;
    else
      r_tmo <= '0;
  end

  assign w_to = (r_tmo == 16'(TIMEOUT_CYC - 1));
`else
  localparam int unused_tmo = TIMEOUT_CYC;
  assign w_to = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // next state and handshake/FIFO strobes
  always_comb begin
    w_next            = r_state;
    bus.icb_cmd_ready = 1'b0;
    bus.icb_rsp_valid = 1'b0;
    bus.wfifo_wen     = 1'b0;
    bus.wfifo_wdata   = '0;
    bus.rfifo_ren     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        bus.icb_cmd_ready = control_en & ~rst;
        if (w_accept) w_next = w_hit ? ST_CMD : ST_RSP;
      end
      ST_CMD: begin
        bus.wfifo_wdata = r_cmd_word;
        bus.wfifo_wen   = ~bus.wfifo_full;
        if (!bus.wfifo_full)
          w_next = r_write ? ST_DATA : ST_RD_WAIT;
      end
      ST_DATA: begin
        bus.wfifo_wdata = r_data_word;
        bus.wfifo_wen   = ~bus.wfifo_full;
        if (!bus.wfifo_full) w_next = ST_RSP;
      end
      ST_RD_WAIT: begin
        bus.rfifo_ren = ~bus.rfifo_empty;
        if (!bus.rfifo_empty) w_next = ST_RD_POP;
        else if (w_to)        w_next = ST_RSP;
      end
      ST_RD_POP: w_next = ST_RSP;
      ST_RSP: begin
        bus.icb_rsp_valid = 1'b1;
        if (bus.icb_rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // latch the command, pre-pack words, capture read data / error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_cmd_word  <= '0;
      r_data_word <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_accept) begin
        r_write     <= ~bus.icb_cmd_read;
        r_err       <= ~w_hit;
        r_rdata     <= '0;
        r_cmd_word  <= pack_cmd(~bus.icb_cmd_read, w_sel, w_addr);
        r_data_word <= pack_data(bus.icb_cmd_wdata[30:0]);
      end
      if (r_state == ST_RD_POP)
        r_rdata <= bus.rfifo_rdata;
      if (r_state == ST_RD_WAIT && w_next == ST_RSP)
        r_err <= 1'b1;
    end
  end

  assign bus.icb_rsp_rdata = (r_state == ST_RSP) ? r_rdata : '0;
  assign bus.icb_rsp_err   = (r_state == ST_RSP) & r_err;

endmodule

// File: tb/tb_icb_wfifo_packer.sv
// tb_icb_wfifo_packer: vector table, hand sequences and random
// transactions against a word-level model of the packer.
module tb_icb_wfifo_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic control_en = 1'b1;

  always #5 clk = ~clk;

  icb_wfifo_packer_if bus();

  icb_wfifo_packer #(.TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .control_en (control_en),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] got_w[$];
  int          got_t[$];
  int          ren_cnt = 0;
  bit          pop_pending = 0;
  logic [31:0] rq[$];
  logic [31:0] rpend = '0;
  bit          rpend_v = 0;
  int          rdelay = 0;
  int          full_left = 0;
  bit          rnd_full = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // observe pushes/pops half a cycle before the edge that commits them
  always @(negedge clk) begin
    if (!rst && bus.wfifo_wen) begin
      chk("wen_while_full", {31'd0, bus.wfifo_full}, 32'd0);
      if (!bus.wfifo_full) begin
        got_w.push_back(bus.wfifo_wdata);
        got_t.push_back(cyc + 1);
      end
    end
    if (!rst && bus.rfifo_ren) begin
      chk("ren_while_empty", {31'd0, bus.rfifo_empty}, 32'd0);
      ren_cnt++;
      if (!bus.rfifo_empty) pop_pending = 1;
    end
  end

  // FIFO-side environment, updated just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pop_pending && rq.size() > 0) begin
        bus.rfifo_rdata = rq.pop_front();
        pop_pending = 0;
      end
      if (rpend_v) begin
        if (rdelay <= 0) begin
          rq.push_back(rpend);
          rpend_v = 0;
        end else begin
          rdelay--;
        end
      end
      bus.rfifo_empty = (rq.size() == 0);
      bus.wfifo_full = (full_left > 0) ||
                       (rnd_full && ($urandom_range(0, 3) == 0));
      if (full_left > 0) full_left--;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  function automatic void model(
    input  logic [31:0] a,
    input  bit          rd,
    input  logic [31:0] wd,
    input  logic [31:0] rdat,
    output bit          err,
    output logic [31:0] rdata,
    output int          nw,
    output logic [31:0] w0,
    output logic [31:0] w1
  );
    int idx;
    err   = (a / 32'h0100_0000) != 32'h10;
    idx   = int'((a / 32'd4096) % 32'd4);
    w0    = (a % 32'h0100_0000) * 32'd256 + (32'd4 << idx)
          + (rd ? 32'd0 : 32'd2);
    w1    = (wd % 32'h8000_0000) * 32'd2 + 32'd1;
    nw    = err ? 0 : (rd ? 1 : 2);
    rdata = (!err && rd) ? rdat : 32'd0;
  endfunction

  task automatic run_txn(
    input  logic [31:0] addr,
    input  bit          rd,
    input  logic [31:0] wd,
    input  logic [31:0] rdat,
    input  int          rdly,
    input  int          fullc,
    input  int          rhold,
    output int          lat,
    output int          tacc,
    output logic [31:0] o_rdata,
    output logic        o_err
  );
    bit ok;
    got_w.delete();
    got_t.delete();
    rq.delete();
    ren_cnt = 0;
    @(posedge clk);
    #1;
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_addr  = addr;
    bus.icb_cmd_read  = rd;
    bus.icb_cmd_wdata = wd;
    bus.icb_rsp_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.icb_cmd_ready) begin
        ok = 1;
        break;
      end
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    tacc = cyc + 1;
    full_left = fullc;
    if (rd && rdly >= 0) begin
      rpend   = rdat;
      rdelay  = rdly;
      rpend_v = 1;
    end
    @(posedge clk);
    #1;
    bus.icb_cmd_valid = 1'b0;
    bus.icb_rsp_ready = (rhold == 0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.icb_rsp_valid) begin
        ok = 1;
        break;
      end
    end
    chk("rsp_timeout", {31'd0, ok}, 32'd1);
    lat     = cyc - tacc + 1;
    o_rdata = bus.icb_rsp_rdata;
    o_err   = bus.icb_rsp_err;
    for (int h = 0; h < rhold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.icb_rsp_valid}, 32'd1);
      chk("hold_rdata", bus.icb_rsp_rdata, o_rdata);
      chk("hold_err", {31'd0, bus.icb_rsp_err}, {31'd0, o_err});
      chk("hold_cmd_ready", {31'd0, bus.icb_cmd_ready}, 32'd0);
    end
    if (rhold > 0) begin
      @(posedge clk);
      #1;
      bus.icb_rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.icb_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          rd;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          rdly;
    int          fullc;
    int          rhold;
    bit          e_err;
    logic [31:0] e_rdata;
    int          e_nw;
    logic [31:0] e_w0;
    logic [31:0] e_w1;
    int          e_lat;
  } vec_t;

  vec_t vt[7];

  initial begin
    int          lat;
    int          tacc;
    logic [31:0] rdata;
    logic        err;
    bit          m_err;
    logic [31:0] m_rdata;
    int          m_nw;
    logic [31:0] m_w0;
    logic [31:0] m_w1;
    bit          ok;

    vt[0] = '{32'h1000_1004, 1'b0, 32'h0000_00AA, 32'h0, -1, 0, 0,
              1'b0, 32'h0, 2, 32'h0010_040A, 32'h0000_0155, 3};
    vt[1] = '{32'h1000_2008, 1'b1, 32'h0, 32'h1234_5678, 5, 0, 0,
              1'b0, 32'h1234_5678, 1, 32'h0020_0810, 32'h0, -1};
    vt[2] = '{32'h2000_0000, 1'b0, 32'h55, 32'h0, -1, 0, 0,
              1'b1, 32'h0, 0, 32'h0, 32'h0, 1};
    vt[3] = '{32'h1000_3FFC, 1'b0, 32'hFFFF_FFFF, 32'h0, -1, 4, 0,
              1'b0, 32'h0, 2, 32'h003F_FC22, 32'hFFFF_FFFF, 7};
    vt[4] = '{32'h10FF_0000, 1'b1, 32'h0, 32'hDEAD_BEEF, 0, 0, 3,
              1'b0, 32'hDEAD_BEEF, 1, 32'hFF00_0004, 32'h0, -1};
    vt[5] = '{32'h0000_1000, 1'b1, 32'h0, 32'h0, -1, 0, 2,
              1'b1, 32'h0, 0, 32'h0, 32'h0, 1};
    vt[6] = '{32'h1000_0000, 1'b0, 32'h8000_0000, 32'h0, -1, 0, 1,
              1'b0, 32'h0, 2, 32'h0000_0006, 32'h0000_0001, 3};

    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_addr  = '0;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_wdata = '0;
    bus.icb_rsp_ready = 1'b0;
    bus.wfifo_full    = 1'b0;
    bus.rfifo_empty   = 1'b1;
    bus.rfifo_rdata   = '0;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.icb_cmd_ready}, 32'd0);
    chk("rst_wen", {31'd0, bus.wfifo_wen}, 32'd0);
    chk("rst_ren", {31'd0, bus.rfifo_ren}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.icb_rsp_valid}, 32'd0);
    chk("rst_rdata", bus.icb_rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, bus.icb_rsp_err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", {31'd0, bus.icb_cmd_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_txn(vt[i].addr, vt[i].rd, vt[i].wd, vt[i].rdat, vt[i].rdly,
              vt[i].fullc, vt[i].rhold, lat, tacc, rdata, err);
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vt[i].e_err});
      chk($sformatf("v%0d_rdata", i), rdata, vt[i].e_rdata);
      if (vt[i].e_lat >= 0)
        chk($sformatf("v%0d_lat", i), lat, vt[i].e_lat);
      chk($sformatf("v%0d_nw", i), got_w.size(), vt[i].e_nw);
      if (vt[i].e_nw >= 1)
        chk($sformatf("v%0d_w0", i),
            got_w.size() > 0 ? got_w[0] : 32'hxxxx_xxxx, vt[i].e_w0);
      if (vt[i].e_nw >= 2)
        chk($sformatf("v%0d_w1", i),
            got_w.size() > 1 ? got_w[1] : 32'hxxxx_xxxx, vt[i].e_w1);
      chk($sformatf("v%0d_pops", i), ren_cnt,
          (vt[i].rd && vt[i].e_nw > 0) ? 1 : 0);
      if (i == 0) begin
        chk("v0_t_cmd", got_t.size() > 0 ? got_t[0] - tacc : -1, 1);
        chk("v0_t_data", got_t.size() > 1 ? got_t[1] - tacc : -1, 2);
      end
    end

    // enable low: no acceptance while a command waits
    @(posedge clk);
    #1;
    control_en = 1'b0;
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_addr  = 32'h1000_1000;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_wdata = 32'h0000_0003;
    got_w.delete();
    repeat (4) begin
      @(negedge clk);
      chk("dis_cmd_ready", {31'd0, bus.icb_cmd_ready}, 32'd0);
    end
    chk("dis_no_push", got_w.size(), 0);

    // enable drops right after accept: transaction still completes
    @(posedge clk);
    #1;
    control_en = 1'b1;
    bus.icb_rsp_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.icb_cmd_ready) begin
        ok = 1;
        break;
      end
    end
    chk("inflight_accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    bus.icb_cmd_valid = 1'b0;
    control_en = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.icb_rsp_valid) begin
        ok = 1;
        break;
      end
    end
    chk("inflight_rsp", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    bus.icb_rsp_ready = 1'b0;
    @(negedge clk);
    chk("inflight_nw", got_w.size(), 2);
    chk("inflight_w1", got_w.size() > 1 ? got_w[1] : 32'hxxxx_xxxx,
        32'h0000_0007);
    chk("inflight_idle_blocked", {31'd0, bus.icb_cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    control_en = 1'b1;

    // random transactions with random WFIFO backpressure
    rnd_full = 1;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd_dat;
      bit          rd;
      int          rdly;
      a[23:0]  = 24'($urandom);
      a[31:24] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h10;
      rd       = 1'($urandom);
      wd       = $urandom;
      rd_dat   = $urandom;
      model(a, rd, wd, rd_dat, m_err, m_rdata, m_nw, m_w0, m_w1);
      rdly = (rd && !m_err) ? int'($urandom_range(0, 6)) : -1;
      run_txn(a, rd, wd, rd_dat, rdly, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), lat, tacc, rdata, err);
      chk($sformatf("r%0d_err", n), {31'd0, err}, {31'd0, m_err});
      chk($sformatf("r%0d_rdata", n), rdata, m_rdata);
      chk($sformatf("r%0d_nw", n), got_w.size(), m_nw);
      if (m_nw >= 1)
        chk($sformatf("r%0d_w0", n),
            got_w.size() > 0 ? got_w[0] : 32'hxxxx_xxxx, m_w0);
      if (m_nw >= 2)
        chk($sformatf("r%0d_w1", n),
            got_w.size() > 1 ? got_w[1] : 32'hxxxx_xxxx, m_w1);
      chk($sformatf("r%0d_pops", n), ren_cnt, (rd && !m_err) ? 1 : 0);
    end
    rnd_full = 0;

`ifdef ICB_PACKER_TIMEOUT_EN
    // read whose data never arrives: watchdog answers with error
    repeat (2) @(negedge clk);
    run_txn(32'h1000_0000, 1'b1, 32'h0, 32'h0, -1, 0, 0,
            lat, tacc, rdata, err);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_rdata", rdata, 32'd0);
    chk("tmo_pops", ren_cnt, 0);
    chk("tmo_lat", lat, 18);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
